// File: rtl/sdram_arbiter.sv
// Command-bus arbiter for the SDRAM controller: init owns the bus until done, then
// refresh (top priority) and round-robin write/read share it; the granted bus is registered to the pins.
module sdram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DQ_W   = 16
) (
  input  logic              i_sysclk,
  input  logic              i_sysrst,
  input  logic [3:0]        i_init_cmd,
  input  logic [1:0]        i_init_ba,
  input  logic [ADDR_W-1:0] i_init_addr,
  input  logic              i_init_done,
  input  logic              i_aref_req,
  input  logic              i_aref_end,
  input  logic [3:0]        i_aref_cmd,
  input  logic [1:0]        i_aref_ba,
  input  logic [ADDR_W-1:0] i_aref_addr,
  output logic              o_aref_en,
  input  logic              i_wr_req,
  input  logic              i_wr_end,
  input  logic [3:0]        i_wr_cmd,
  input  logic [1:0]        i_wr_ba,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DQ_W-1:0]   i_wr_data,
  input  logic              i_wr_dq_oe,
  output logic              o_wr_en,
  input  logic              i_rd_req,
  input  logic              i_rd_end,
  input  logic [3:0]        i_rd_cmd,
  input  logic [1:0]        i_rd_ba,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_en,
  output logic              o_sdram_cke,
  output logic              o_sdram_cs_n,
  output logic              o_sdram_ras_n,
  output logic              o_sdram_cas_n,
  output logic              o_sdram_we_n,
  output logic [1:0]        o_sdram_ba,
  output logic [ADDR_W-1:0] o_sdram_addr,
  output logic [DQ_W-1:0]   o_sdram_dq,
  output logic              o_sdram_dq_oe
);

  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    ARB_INIT  = 3'd0,
    ARB_IDLE  = 3'd1,
    ARB_AREF  = 3'd2,
    ARB_WRITE = 3'd3,
    ARB_READ  = 3'd4
  } arb_state_t;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_t;

  arb_state_t state, state_nxt;
  rw_t        last_rw, last_rw_nxt;

  logic [3:0]        cmd_p0;
  logic [1:0]        ba_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DQ_W-1:0]   dq_p0;
  logic              dq_oe_p0;

  logic [3:0]        cmd_p1;
  logic [1:0]        ba_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DQ_W-1:0]   dq_p1;
  logic              dq_oe_p1;
  logic              cke_p1;
  logic              aref_en_p1;
  logic              wr_en_p1;
  logic              rd_en_p1;

  // Refresh first; on a write/read tie the side not served last wins.
  function automatic arb_state_t pick_grant(
    input logic aref,
    input logic wr,
    input logic rd,
    input rw_t  last
  );
    arb_state_t sel;
    sel = ARB_IDLE;
    if (aref)
      sel = ARB_AREF;
    else if (wr && rd)
      sel = (last == RW_READ) ? ARB_WRITE : ARB_READ;
    else if (wr)
      sel = ARB_WRITE;
    else if (rd)
      sel = ARB_READ;
    return sel;
  endfunction

  always_comb begin
    state_nxt   = state;
    last_rw_nxt = last_rw;
    case (state)
      ARB_INIT:  if (i_init_done) state_nxt = ARB_IDLE;
      ARB_IDLE: begin
        state_nxt = pick_grant(i_aref_req, i_wr_req, i_rd_req, last_rw);
        if (state_nxt == ARB_WRITE)
          last_rw_nxt = RW_WRITE;
        else if (state_nxt == ARB_READ)
          last_rw_nxt = RW_READ;
      end
      ARB_AREF:  if (i_aref_end) state_nxt = ARB_IDLE;
      ARB_WRITE: if (i_wr_end)   state_nxt = ARB_IDLE;
      ARB_READ:  if (i_rd_end)   state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_INIT;
    endcase
  end

  // Stage p0: bus selected by the state the arbiter is in this cycle
  always_comb begin
    cmd_p0   = CMD_NOP;
    ba_p0    = 2'b11;
    addr_p0  = '1;
    dq_p0    = '0;
    dq_oe_p0 = 1'b0;
    case (state)
      ARB_INIT: begin
        cmd_p0  = i_init_cmd;
        ba_p0   = i_init_ba;
        addr_p0 = i_init_addr;
      end
      ARB_AREF: begin
        cmd_p0  = i_aref_cmd;
        ba_p0   = i_aref_ba;
        addr_p0 = i_aref_addr;
      end
      ARB_WRITE: begin
        cmd_p0   = i_wr_cmd;
        ba_p0    = i_wr_ba;
        addr_p0  = i_wr_addr;
        dq_p0    = i_wr_data;
        dq_oe_p0 = i_wr_dq_oe;
      end
      ARB_READ: begin
        cmd_p0  = i_rd_cmd;
        ba_p0   = i_rd_ba;
        addr_p0 = i_rd_addr;
      end
      default: ;
    endcase
  end

  // Stage p1: state, grants and pin registers
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state      <= ARB_INIT;
      last_rw    <= RW_READ;
      aref_en_p1 <= 1'b0;
      wr_en_p1   <= 1'b0;
      rd_en_p1   <= 1'b0;
      cke_p1     <= 1'b1;
      cmd_p1     <= CMD_NOP;
      ba_p1      <= 2'b11;
      addr_p1    <= '1;
      dq_p1      <= '0;
      dq_oe_p1   <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_rw    <= last_rw_nxt;
      aref_en_p1 <= (state_nxt == ARB_AREF);
      wr_en_p1   <= (state_nxt == ARB_WRITE);
      rd_en_p1   <= (state_nxt == ARB_READ);
      cke_p1     <= 1'b1;
      cmd_p1     <= cmd_p0;
      ba_p1      <= ba_p0;
      addr_p1    <= addr_p0;
      dq_p1      <= dq_p0;
      dq_oe_p1   <= dq_oe_p0;
    end
  end

  assign o_aref_en     = aref_en_p1;
  assign o_wr_en       = wr_en_p1;
  assign o_rd_en       = rd_en_p1;
  assign o_sdram_cke   = cke_p1;
  assign o_sdram_cs_n  = cmd_p1[3];
  assign o_sdram_ras_n = cmd_p1[2];
  assign o_sdram_cas_n = cmd_p1[1];
  assign o_sdram_we_n  = cmd_p1[0];
  assign o_sdram_ba    = ba_p1;
  assign o_sdram_addr  = addr_p1;
  assign o_sdram_dq    = dq_p1;
  assign o_sdram_dq_oe = dq_oe_p1;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: a bus-ownership model predicts pins and grant
// events per cycle; a monitor compares what the arbiter presents.
module tb_sdram_arbiter;
  localparam int ADDR_W = 13;
  localparam int DQ_W   = 16;
  localparam int O_INIT = 0, O_IDLE = 1, O_AREF = 2, O_WR = 3, O_RD = 4;
  localparam logic [36:0] NOP_PINS = {1'b1, 4'b0111, 2'b11, 13'h1fff, 16'h0000, 1'b0};
  localparam logic [39:0] NOP_VEC  = {NOP_PINS, 3'b000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] i_init_cmd, i_aref_cmd, i_wr_cmd, i_rd_cmd;
  logic [1:0] i_init_ba, i_aref_ba, i_wr_ba, i_rd_ba;
  logic [ADDR_W-1:0] i_init_addr, i_aref_addr, i_wr_addr, i_rd_addr;
  logic i_init_done, i_aref_req, i_aref_end, i_wr_req, i_wr_end, i_rd_req, i_rd_end;
  logic [DQ_W-1:0] i_wr_data;
  logic i_wr_dq_oe;
  logic o_aref_en, o_wr_en, o_rd_en, o_sdram_cke;
  logic o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n, o_sdram_dq_oe;
  logic [1:0] o_sdram_ba;
  logic [ADDR_W-1:0] o_sdram_addr;
  logic [DQ_W-1:0] o_sdram_dq;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DQ_W(DQ_W)) dut (
    .i_sysclk(clk), .i_sysrst(rst),
    .i_init_cmd(i_init_cmd), .i_init_ba(i_init_ba), .i_init_addr(i_init_addr),
    .i_init_done(i_init_done),
    .i_aref_req(i_aref_req), .i_aref_end(i_aref_end), .i_aref_cmd(i_aref_cmd),
    .i_aref_ba(i_aref_ba), .i_aref_addr(i_aref_addr), .o_aref_en(o_aref_en),
    .i_wr_req(i_wr_req), .i_wr_end(i_wr_end), .i_wr_cmd(i_wr_cmd), .i_wr_ba(i_wr_ba),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wr_dq_oe(i_wr_dq_oe), .o_wr_en(o_wr_en),
    .i_rd_req(i_rd_req), .i_rd_end(i_rd_end), .i_rd_cmd(i_rd_cmd), .i_rd_ba(i_rd_ba),
    .i_rd_addr(i_rd_addr), .o_rd_en(o_rd_en),
    .o_sdram_cke(o_sdram_cke), .o_sdram_cs_n(o_sdram_cs_n), .o_sdram_ras_n(o_sdram_ras_n),
    .o_sdram_cas_n(o_sdram_cas_n), .o_sdram_we_n(o_sdram_we_n), .o_sdram_ba(o_sdram_ba),
    .o_sdram_addr(o_sdram_addr), .o_sdram_dq(o_sdram_dq), .o_sdram_dq_oe(o_sdram_dq_oe)
  );

  typedef struct packed {
    int who;
    int at;
  } gev_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [39:0] pin_q[$];
  gev_t        ev_q[$];

  // Model state: who owns the bus this cycle, plus requester agents
  int owner;
  bit last_was_wr;
  int rr_grants;
  bit pend[3];
  bit auto_rq[3];
  bit endv[3];
  int len[3];
  int cnt[3];
  bit rnd_mode;
  bit prech;
  bit init_done_v;

  logic [39:0] mon_act, mon_exp;
  logic [2:0]  mon_g, mon_prev_g;
  gev_t        mon_ev;

  function automatic logic [39:0] dut_vec();
    return {o_sdram_cke, o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n,
            o_sdram_ba, o_sdram_addr, o_sdram_dq, o_sdram_dq_oe, o_aref_en, o_wr_en, o_rd_en};
  endfunction

  function automatic logic [2:0] who_vec(input int who);
    return {who == O_AREF, who == O_WR, who == O_RD};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_and_step();
    logic [36:0] pins;
    int nxt;
    i_init_cmd  = prech ? 4'b0010 : 4'($urandom);
    i_init_ba   = 2'($urandom);
    i_init_addr = ADDR_W'($urandom);
    i_init_done = init_done_v;
    i_aref_cmd  = 4'($urandom);
    i_aref_ba   = 2'($urandom);
    i_aref_addr = ADDR_W'($urandom);
    i_wr_cmd    = 4'($urandom);
    i_wr_ba     = 2'($urandom);
    i_wr_addr   = ADDR_W'($urandom);
    i_wr_data   = rnd_mode ? DQ_W'($urandom) : 16'hA5A5;
    i_wr_dq_oe  = rnd_mode ? 1'($urandom) : 1'b1;
    i_rd_cmd    = 4'($urandom);
    i_rd_ba     = 2'($urandom);
    i_rd_addr   = ADDR_W'($urandom);
    for (int r = 0; r < 3; r++) begin
      if (owner == O_AREF + r) begin
        pend[r] = 1'b0;
        cnt[r]++;
        endv[r] = (cnt[r] >= len[r]);
        if (endv[r] && auto_rq[r]) pend[r] = 1'b1;
      end else begin
        cnt[r]  = 0;
        endv[r] = rnd_mode && ($urandom_range(0, 15) == 0);
        if (rnd_mode && !pend[r] && $urandom_range(0, 7) == 0) begin
          pend[r] = 1'b1;
          len[r]  = $urandom_range(1, 8);
        end
      end
    end
    i_aref_req = pend[0];  i_aref_end = endv[0];
    i_wr_req   = pend[1];  i_wr_end   = endv[1];
    i_rd_req   = pend[2];  i_rd_end   = endv[2];

    case (owner)
      O_INIT:  pins = {1'b1, i_init_cmd, i_init_ba, i_init_addr, 16'h0, 1'b0};
      O_AREF:  pins = {1'b1, i_aref_cmd, i_aref_ba, i_aref_addr, 16'h0, 1'b0};
      O_WR:    pins = {1'b1, i_wr_cmd, i_wr_ba, i_wr_addr, i_wr_data, i_wr_dq_oe};
      O_RD:    pins = {1'b1, i_rd_cmd, i_rd_ba, i_rd_addr, 16'h0, 1'b0};
      default: pins = NOP_PINS;
    endcase
    nxt = owner;
    if (owner == O_INIT) begin
      if (i_init_done) nxt = O_IDLE;
    end else if (owner == O_IDLE) begin
      if (i_aref_req)              nxt = O_AREF;
      else if (i_wr_req && i_rd_req) nxt = last_was_wr ? O_RD : O_WR;
      else if (i_wr_req)           nxt = O_WR;
      else if (i_rd_req)           nxt = O_RD;
      if (nxt != O_IDLE) begin
        ev_q.push_back(gev_t'{nxt, cyc + 1});
        if (nxt != O_AREF) begin
          last_was_wr = (nxt == O_WR);
          rr_grants++;
        end
      end
    end else if (endv[owner - O_AREF]) begin
      nxt = O_IDLE;
    end
    pin_q.push_back({pins, who_vec(nxt)});
    owner = nxt;
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_and_step();
  endtask

  task automatic wait_owner(input int o);
    int n = 0;
    while (owner != o && n < 200) begin cycle(); n++; end
    if (owner != o) begin
      checks++; errors++;
      $display("FAIL wait_owner: model owner %0d required %0d after %0d cycles", owner, o, n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((owner != O_IDLE || pend[0] || pend[1] || pend[2]) && n < 400) begin cycle(); n++; end
    if (owner != O_IDLE) begin
      checks++; errors++;
      $display("FAIL drain: bus still owned (%0d) after %0d cycles", owner, n);
    end
  endtask

  task automatic model_reset();
    owner = O_INIT; last_was_wr = 1'b0; rr_grants = 0;
    for (int r = 0; r < 3; r++) begin
      pend[r] = 0; auto_rq[r] = 0; endv[r] = 0; cnt[r] = 0; len[r] = 2;
    end
    rnd_mode = 0; prech = 0; init_done_v = 0;
  endtask

  // Monitor: compare presented pins/grants against the scoreboard
  initial begin
    mon_prev_g = 3'b000;
    forever begin
      @(posedge clk); #1;
      mon_act = dut_vec();
      mon_g   = mon_act[2:0];
      if (pin_q.size() > 0) begin
        mon_exp = pin_q.pop_front();
        check("pins_grants", mon_act, mon_exp);
      end
      if (mon_g != 3'b000 && mon_g != mon_prev_g) begin
        if (ev_q.size() == 0) check("unexpected_grant", mon_g, 3'b000);
        else begin
          mon_ev = ev_q.pop_front();
          check("grant_who", mon_g, who_vec(mon_ev.who));
          check("grant_cycle", cyc, mon_ev.at);
        end
      end
      mon_prev_g = mon_g;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int base, n;
    model_reset();
    i_init_cmd = 0; i_init_ba = 0; i_init_addr = 0; i_init_done = 0;
    i_aref_req = 0; i_aref_end = 0; i_aref_cmd = 0; i_aref_ba = 0; i_aref_addr = 0;
    i_wr_req = 0; i_wr_end = 0; i_wr_cmd = 0; i_wr_ba = 0; i_wr_addr = 0;
    i_wr_data = 0; i_wr_dq_oe = 0;
    i_rd_req = 0; i_rd_end = 0; i_rd_cmd = 0; i_rd_ba = 0; i_rd_addr = 0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", dut_vec(), NOP_VEC);

    // Init: PRECHARGE at cycle 5, done at 40, write held from 10, read from 12
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (k == 0) rst = 1'b0;
      prech = (k == 5);
      init_done_v = (k >= 40);
      if (k == 10) begin pend[1] = 1; len[1] = 3; end
      if (k == 12) begin pend[2] = 1; len[2] = 2; end
      drive_and_step();
    end
    drain();

    // Priority: all three in the same cycle
    pend[0] = 1; pend[1] = 1; pend[2] = 1;
    len[0] = 2; len[1] = 3; len[2] = 2;
    drain();

    // Round robin over 4 bursts, requests re-raised with each end pulse
    auto_rq[1] = 1; auto_rq[2] = 1; pend[1] = 1; pend[2] = 1;
    len[1] = 2; len[2] = 3;
    base = rr_grants; n = 0;
    while (rr_grants < base + 4 && n < 200) begin cycle(); n++; end
    auto_rq[1] = 0; auto_rq[2] = 0;
    drain();

    // Refresh raised mid-write with a read also pending
    pend[1] = 1; len[1] = 6;
    wait_owner(O_WR);
    cycle(); cycle();
    pend[0] = 1; pend[2] = 1; len[0] = 2; len[2] = 2;
    drain();

    // Random traffic with spurious end pulses and a toggling init_done
    rnd_mode = 1;
    repeat (3000) begin
      init_done_v = 1'($urandom);
      cycle();
    end
    rnd_mode = 0;
    drain();

    // Asynchronous reset in the middle of a read
    pend[2] = 1; len[2] = 50;
    wait_owner(O_RD);
    cycle(); cycle();
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("rst_rd_en", o_rd_en, 1'b0);
    check("rst_pins_async", dut_vec(), NOP_VEC);
    @(posedge clk); #1 check("rst_hold", dut_vec(), NOP_VEC);
    model_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) rst = 1'b0;
      init_done_v = (k >= 12);
      if (k == 2) begin pend[1] = 1; pend[2] = 1; end
      drive_and_step();
    end
    drain();

    cycle(); cycle();
    @(posedge clk); #2;
    check("queues_drained", pin_q.size() + ev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
